// File: rtl/truth_table_checker_pkg.sv
// Shared state encoding and golden-table row lookup
// for the truth table self-test checker.
package truth_table_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int TBL_MAX = 1024;
  localparam int ROW_MAX = 32;

  function automatic logic [ROW_MAX-1:0] get_row(
    input logic [TBL_MAX-1:0] tbl,
    input int                 idx,
    input int                 w
  );
    logic [ROW_MAX-1:0] r;
    r = '0;
    for (int b = 0; b < ROW_MAX; b++) begin
      if (b < w && (idx * w + b) < TBL_MAX)
        r[b] = tbl[idx*w+b];
    end
    return r;
  endfunction

endpackage

// File: rtl/truth_table_checker_settle_timer.sv
// Per-vector hold counter; tick marks the sample edge.
// With SETTLE=1 the count never leaves 0, so tick is constant.
module settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && !tick)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/truth_table_checker.sv
// Exhaustive BIST response checker: sweeps every input
// vector and compares the DUT response to a golden table.
module truth_table_checker
  import truth_table_checker_pkg::*;
#(
  parameter int IN_W   = 3,
  parameter int OUT_W  = 2,
  parameter int SETTLE = 2,
  parameter logic [(2**IN_W)*OUT_W-1:0] EXPECTED =
    {(2**IN_W)*OUT_W{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [OUT_W-1:0] dut_out,
  output logic [IN_W-1:0]  dut_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IN_W:0]    err_cnt,
  output logic [IN_W-1:0]  first_fail_vec,
  output logic [OUT_W-1:0] first_fail_got
);

  localparam logic [IN_W-1:0] LAST_VEC = '1;

  state_t state, state_nx;

  logic tick;
  logic go;
  logic sample;
  logic last;
  logic miss;

  logic [TBL_MAX-1:0] tbl_ext;
  logic [ROW_MAX-1:0] row_full;

  assign tbl_ext  = TBL_MAX'(EXPECTED);
  assign row_full = get_row(tbl_ext, int'(dut_in), OUT_W);
  assign miss     = (dut_out != row_full[OUT_W-1:0]);

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == '0);

  // A restart from DONE loses to a simultaneous abort
  assign go     = start && ((state == IDLE) ||
                            (state == DONE && !abort));
  assign sample = busy && !abort && tick;
  assign last   = (dut_in == LAST_VEC);

  settle_timer #(
    .SETTLE(SETTLE)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (go || (sample && !last)),
    .en  (busy && !abort),
    .tick(tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (go) state_nx = RUN;
      RUN: begin
        if (abort)
          state_nx = IDLE;
        else if (sample && last)
          state_nx = DONE;
      end
      DONE: begin
        if (abort)
          state_nx = IDLE;
        else if (go)
          state_nx = RUN;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dut_in         <= '0;
      err_cnt        <= '0;
      first_fail_vec <= '0;
      first_fail_got <= '0;
    end else if (go) begin
      dut_in         <= '0;
      err_cnt        <= '0;
      first_fail_vec <= '0;
      first_fail_got <= '0;
    end else if (sample) begin
      if (miss) begin
        err_cnt <= err_cnt + 1'b1;
        if (err_cnt == '0) begin
          first_fail_vec <= dut_in;
          first_fail_got <= dut_out;
        end
      end
      if (!last)
        dut_in <= dut_in + 1'b1;
    end
  end

endmodule
